// File: rtl/noc_pkg.sv
// Shared router constants, port/lock enums and the round-robin index helper.
package noc_pkg;

    localparam int NPORT  = 5;
    localparam int PORT_W = 3;

    typedef enum logic [PORT_W-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } port_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_e;

    // Next port index modulo NPORT.
    function automatic logic [PORT_W-1:0] port_inc(input logic [PORT_W-1:0] p);
        return (p >= PORT_W'(NPORT - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/sw_out_arb.sv
// Per-output arbiter: round-robin among candidates, wormhole lock from head to tail, credit gated.
//   state  | meaning
//   IDLE   | no packet in flight; RR scan from r_ptr picks the winner
//   LOCKED | packet from r_owner in flight; only r_owner may be granted
module sw_out_arb
    import noc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NPORT-1:0]  i_cand,
    input  logic              i_credit,
    input  logic [NPORT-1:0]  i_tail,
    output logic [NPORT-1:0]  o_win,
    output logic              o_valid,
    output logic [PORT_W-1:0] o_sel
);

    lock_e             r_state, w_state_nxt;
    logic [PORT_W-1:0] r_owner, w_owner_nxt;
    logic [PORT_W-1:0] r_ptr, w_ptr_nxt;
    logic              w_found;
    logic [PORT_W-1:0] w_win_idx;

    always_comb begin
        logic [PORT_W-1:0] v_idx;
        w_found   = 1'b0;
        w_win_idx = '0;
        v_idx     = r_ptr;
        if (r_state == LOCKED) begin
            w_found   = i_cand[r_owner];
            w_win_idx = r_owner;
        end else begin
            for (int k = 0; k < NPORT; k++) begin
                if (!w_found && i_cand[v_idx]) begin
                    w_found   = 1'b1;
                    w_win_idx = v_idx;
                end
                v_idx = port_inc(v_idx);
            end
        end
        // Outputs are held quiet while reset is asserted, not just after the first edge.
        w_found = w_found && i_credit && rst;
    end

    always_comb begin
        o_win   = '0;
        o_valid = w_found;
        o_sel   = '0;
        if (w_found) begin
            o_win[w_win_idx] = 1'b1;
            o_sel            = w_win_idx;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        if (w_found) begin
            if (i_tail[w_win_idx]) begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = port_inc(w_win_idx);
            end else begin
                w_state_nxt = LOCKED;
                w_owner_nxt = w_win_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/sw_alloc.sv
// Switch allocator for the 5-port router: one lock/RR arbiter per output, grants ORed per input.
module sw_alloc
    import noc_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NPORT-1:0]              sw_req,
    input  logic [NPORT-1:0][PORT_W-1:0]  dest,
    input  logic [NPORT-1:0]              tail,
    input  logic [NPORT-1:0]              credit_ok,
    output logic [NPORT-1:0]              grant,
    output logic [NPORT-1:0][PORT_W-1:0]  xbar_sel,
    output logic [NPORT-1:0]              out_valid
);

    logic [NPORT-1:0][NPORT-1:0] w_cand;
    logic [NPORT-1:0][NPORT-1:0] w_win;

    // Destinations above the last port match no output and are never granted.
    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                w_cand[o][i] = sw_req[i] && (dest[i] == PORT_W'(o));
            end
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_out
        sw_out_arb u_arb (
            .clk      (clk),
            .rst      (rst),
            .i_cand   (w_cand[o]),
            .i_credit (credit_ok[o]),
            .i_tail   (tail),
            .o_win    (w_win[o]),
            .o_valid  (out_valid[o]),
            .o_sel    (xbar_sel[o])
        );
    end

    always_comb begin
        grant = '0;
        for (int o = 0; o < NPORT; o++) begin
            grant = grant | w_win[o];
        end
    end

endmodule

// File: tb/tb_sw_alloc.sv
// Scoreboard bench for sw_alloc: directed scenarios plus constrained-random traffic vs a reference model.
module tb_sw_alloc;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       sw_req;
    logic [4:0][2:0]  dest;
    logic [4:0]       tail;
    logic [4:0]       credit_ok;
    logic [4:0]       grant;
    logic [4:0][2:0]  xbar_sel;
    logic [4:0]       out_valid;

    sw_alloc dut (
        .clk       (clk),
        .rst       (rst),
        .sw_req    (sw_req),
        .dest      (dest),
        .tail      (tail),
        .credit_ok (credit_ok),
        .grant     (grant),
        .xbar_sel  (xbar_sel),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      g;
        logic [4:0]      v;
        logic [4:0][2:0] s;
        int              cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_n    = 0;

    // Reference model: per output, locked flag, owner and rr pointer as plain ints.
    int         m_lock[5];
    int         m_own[5];
    int         m_ptr[5];
    logic [4:0] last_g;

    task automatic model_reset();
        for (int o = 0; o < 5; o++) begin
            m_lock[o] = 0; m_own[o] = 0; m_ptr[o] = 0;
        end
    endtask

    task automatic step();
        exp_t e;
        e.g = '0; e.v = '0; e.s = '0; e.cyc = cyc_n;
        if (!rst) begin
            model_reset();
        end else begin
            for (int o = 0; o < 5; o++) begin
                int w;
                w = -1;
                if (credit_ok[o]) begin
                    if (m_lock[o] != 0) begin
                        if (sw_req[m_own[o]] && int'(dest[m_own[o]]) == o) w = m_own[o];
                    end else begin
                        for (int k = 0; k < 5; k++) begin
                            int i;
                            i = (m_ptr[o] + k) % 5;
                            if (w < 0 && sw_req[i] && int'(dest[i]) == o) w = i;
                        end
                    end
                end
                if (w >= 0) begin
                    e.g[w] = 1'b1;
                    e.v[o] = 1'b1;
                    e.s[o] = 3'(w);
                    if (tail[w]) begin
                        m_lock[o] = 0;
                        m_ptr[o]  = (w + 1) % 5;
                    end else if (m_lock[o] == 0) begin
                        m_lock[o] = 1;
                        m_own[o]  = w;
                    end
                end
            end
        end
        last_g = e.g;
        q.push_back(e);
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the DUT against the oldest expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (grant !== e.g || out_valid !== e.v || xbar_sel !== e.s) begin
                    failures++;
                    $display("FAIL alloc cyc%0d: grant=%b valid=%b sel=%h required grant=%b valid=%b sel=%h",
                             e.cyc, grant, out_valid, xbar_sel, e.g, e.v, e.s);
                end
            end
        end
    end

    int left[5];
    int bad_age[5];

    task automatic rand_inputs();
        rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
        for (int o = 0; o < 5; o++) credit_ok[o] = ($urandom_range(0, 4) != 0);
        for (int i = 0; i < 5; i++) begin
            if (sw_req[i] && !last_g[i]) begin
                // Held request; abandon an unroutable one after a while.
                if (dest[i] > 3'd4) begin
                    bad_age[i]++;
                    if (bad_age[i] > 6) begin
                        sw_req[i] = 1'b0;
                        left[i]   = 0;
                    end
                end
            end else begin
                if (last_g[i]) left[i]--;
                if (left[i] == 0 && $urandom_range(0, 2) == 0) begin
                    left[i]    = $urandom_range(1, 3);
                    bad_age[i] = 0;
                    if ($urandom_range(0, 15) == 0) begin
                        dest[i] = 3'($urandom_range(5, 7));
                        left[i] = 1;
                    end else begin
                        dest[i] = 3'($urandom_range(0, 4));
                    end
                end
                sw_req[i] = (left[i] > 0) && ($urandom_range(0, 3) != 0);
                tail[i]   = (left[i] == 1);
            end
        end
    endtask

    initial begin
        rst = 1'b0; sw_req = '0; dest = '0; tail = '0; credit_ok = '1; last_g = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset holds outputs low despite full requests, then ptr=0 ordering.
        sw_req = 5'b11111; tail = 5'b11111;
        repeat (3) step();
        rst = 1'b1;
        repeat (6) step();
        sw_req = '0; step();

        // Round-robin between inputs 1 and 3 on output 2.
        sw_req = 5'b01010; dest[1] = 3'd2; dest[3] = 3'd2; tail = 5'b11111;
        repeat (3) step();
        sw_req = '0; step();

        // Wormhole: 3-flit packet from input 0 to output 4 while input 2 waits.
        sw_req = 5'b00101; dest[0] = 3'd4; dest[2] = 3'd4; tail = 5'b00100;
        step(); step();
        tail[0] = 1'b1; step();
        sw_req[0] = 1'b0; step();
        sw_req = '0; step();

        // Credit stall on output 3.
        sw_req = 5'b10000; dest[4] = 3'd3; tail = 5'b11111; credit_ok = 5'b10111;
        repeat (4) step();
        credit_ok = '1; step();
        sw_req = '0; step();

        // All five outputs granted in parallel.
        dest[0] = 3'd1; dest[1] = 3'd2; dest[2] = 3'd3; dest[3] = 3'd4; dest[4] = 3'd0;
        sw_req = 5'b11111; tail = 5'b11111;
        step();
        sw_req = '0; step();

        // Lock output 1 to input 2, reset mid-packet; input 3 asks for nonexistent port 6.
        sw_req = 5'b01100; dest[2] = 3'd1; dest[3] = 3'd6; tail = 5'b01000;
        step();
        sw_req = 5'b01101; dest[0] = 3'd1; tail = 5'b01001;
        step();
        rst = 1'b0; step();
        rst = 1'b1; step(); step();
        sw_req = '0; tail = '0; step();

        for (int i = 0; i < 5; i++) begin left[i] = 0; bad_age[i] = 0; end
        last_g = '0;
        repeat (3000) begin
            rand_inputs();
            step();
        end
        rst = 1'b1; sw_req = '0;
        step();

        for (int n = 0; n < 10 && q.size() != 0; n++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sw_alloc.md
Name: sw_alloc

Overview:
- Switch allocator for the 5-port router. Shares the five output ports of the crossbar among the five input ports.
- Sits between the input-port array (which raises per-input switch requests) and the crossbar/output stage.
- Per output: round-robin arbitration plus a wormhole lock held from head flit to tail flit, gated by downstream credit.
- Produces per-input dequeue grants and per-output crossbar select.

Parameters:
- NPORT, 5, number of router ports (inputs = outputs); design and bench target 5 only.
- PORT_W, 3, width of a port index.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-low reset.
- sw_req  input  [NPORT-1:0] x 1  input i has a flit at FIFO head requesting the switch.
- dest  input  [NPORT-1:0] x PORT_W  requested output port of input i, 0..4.
- tail  input  [NPORT-1:0] x 1  flit at head of input i is a tail (single-flit packet = tail with no prior lock).
- credit_ok  input  [NPORT-1:0] x 1  output o has at least one downstream credit this cycle.
- grant  output  [NPORT-1:0] x 1  input i's flit crosses the switch this cycle; input pops its FIFO.
- xbar_sel  output  [NPORT-1:0] x PORT_W  input index driving output o.
- out_valid  output  [NPORT-1:0] x 1  output o carries a valid flit this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - All output locks -> IDLE; all RR pointers -> 0; owner registers -> 0.
  - grant, out_valid and xbar_sel are forced 0 while rst=0.
- Timing:
  - grant, xbar_sel and out_valid are combinational from the current inputs and registered state: zero-cycle latency.
  - Lock and pointer state update on the rising edge of clk.
- Requester rules:
  - Requester holds sw_req, dest and tail stable until granted.
  - Each input names exactly one output, so at most one grant per input per cycle; no input-side arbitration.
- Candidate set for output o: {i : sw_req[i] && dest[i]==o}. Requests with dest > 4 are ignored: never granted, no state change.
- Per-output FSM, IDLE:
  - If candidate set is non-empty and credit_ok[o]=1: winner = first candidate scanning ptr[o], ptr[o]+1, ... mod 5.
  - On a win: grant[winner]=1, out_valid[o]=1, xbar_sel[o]=winner.
  - If tail[winner]=0: go to LOCKED, owner[o] <= winner, ptr unchanged.
  - If tail[winner]=1: stay IDLE, ptr[o] <= (winner+1) mod 5.
- Per-output FSM, LOCKED:
  - Only owner[o] is eligible; all other candidates are ignored.
  - Grant the owner when sw_req[owner] && dest[owner]==o && credit_ok[o].
  - On a granted tail: go to IDLE, ptr[o] <= (owner+1) mod 5.
  - Owner bubble (no request that cycle): stay LOCKED, no grant, out_valid[o]=0.
- Credit:
  - credit_ok[o]=0 means no grant on o.
  - State, pointer and lock are unchanged while credit is absent.
- Outputs are independent: up to 5 grants in one cycle when destinations are distinct.
- xbar_sel[o] is 0 whenever out_valid[o]=0.
- Reset mid-packet drops all locks. Upstream recovery is out of scope.

Decomposition:
- Shared package noc_pkg:
  - NPORT and PORT_W constants.
  - Port enum LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4.
  - Lock-state typedef {IDLE, LOCKED}.
- Sub-module sw_out_arb: one per output, instantiated NPORT times. Holds the lock FSM, owner register and 5-way RR pointer; takes the candidate vector, credit_ok and tail; returns the winner one-hot and valid.
- sw_alloc ORs the per-output winner one-hots into grant.

Test Plan:
- Reset:
  - Hold rst=0 with sw_req=5'b11111 and credit_ok=all 1 -> grant=0, out_valid=0.
  - Release rst -> first grant follows ptr=0 ordering.
- Round-robin:
  - Inputs 1 and 3 both request dest=2 with tail=1, credit ok, held.
  - Cycle 0: grant=5'b00010, xbar_sel[2]=1.
  - Cycle 1: grant=5'b01000, xbar_sel[2]=3.
  - Cycle 2: input 1 again.
- Wormhole lock:
  - Input 0 sends a 3-flit packet (tail on flit 3) to dest=4; input 2 requests dest=4 throughout.
  - Input 0 is granted for 3 cycles; input 2 is first granted the cycle after the tail; ptr[4]=1.
- Credit stall:
  - Input 4 requests dest=3 with credit_ok[3]=0 for 4 cycles -> no grant, no state change.
  - credit_ok[3]=1 -> grant[4]=1 that same cycle.
- Parallel:
  - Inputs 0..4 request dests 1, 2, 3, 4, 0, all tail -> grant=5'b11111 in one cycle, xbar_sel={3,2,1,0,4} for outputs 4..0.
- Reset mid-packet / bad dest:
  - Assert rst while output 1 is LOCKED to input 2 -> after release, input 0 wins output 1 against input 2.
  - dest=6 is never granted.
